regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the 32x32 MIPS register file, for the pipelined core.
- Provides two combinational read ports and one synchronous write port.
- Adds optional write-to-read bypass, a per-register busy scoreboard for in-flight writes with an issue handshake, and a sequential post-reset clear engine so the storage can map to RAM.
- Sits between decode (reads, issue), writeback (writes) and the hazard unit (busy flags).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers (derived, not overridable).
- BYPASS, 1, 1 = a read of the address being written this cycle returns WriteData; 0 = returns the stored value.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- Ready  out  1  high once the clear sequence has finished.
- RegWrite  in  1  write enable (writeback).
- WriteAddr  in  ADDR_W  write address.
- WriteData  in  DATA_W  write data.
- ReadAddr1  in  ADDR_W  read port 1 address.
- ReadAddr2  in  ADDR_W  read port 2 address.
- ReadData1  out  DATA_W  read port 1 data (combinational).
- ReadData2  out  DATA_W  read port 2 data (combinational).
- Busy1  out  1  register at ReadAddr1 has a pending write.
- Busy2  out  1  register at ReadAddr2 has a pending write.
- IssueValid  in  1  decode requests to mark IssueAddr as pending.
- IssueAddr  in  ADDR_W  destination register of the issuing instruction.
- IssueReady  out  1  issue accepted this cycle if IssueValid is high.

Behaviour:
- Reset (reset=0 at clock edge):
  - state <= CLEAR, clear pointer <= 1, all busy bits <= 0, Ready <= 0.
  - Storage contents are not touched directly by reset.
- FSM, states CLEAR and RUN:
  - CLEAR: each cycle writes 0 to mem[ptr] and increments ptr.
  - When ptr == DEPTH-1, that entry is written and state <= RUN.
  - CLEAR lasts DEPTH-1 cycles after reset deasserts.
  - Ready = (state == RUN), registered; it rises on the edge that enters RUN.
- During CLEAR:
  - ReadData1/2 forced to 0.
  - Busy1/2 = 0, IssueReady = 0.
  - RegWrite and IssueValid are ignored.
- Reset asserted during CLEAR or RUN: the sequence restarts from ptr=1; all pending busy state is discarded.
- Address 0:
  - Always reads 0.
  - Writes to it are ignored.
  - Never marked busy; issue to it is always accepted in RUN (no effect).
- Write, RUN only: on edge, if RegWrite and WriteAddr != 0, mem[WriteAddr] <= WriteData and busy[WriteAddr] <= 0.
- Read (combinational):
  - ReadDataN = 0 if ReadAddrN == 0.
  - Otherwise WriteData if BYPASS and RegWrite and ReadAddrN == WriteAddr and state == RUN.
  - Otherwise mem[ReadAddrN].
- Busy flags (combinational): BusyN = busy[ReadAddrN] & (ReadAddrN != 0), cleared to 0 when a bypass hit on that port applies this cycle.
  - With BYPASS=0, BusyN stays as stored until the edge.
- Issue handshake:
  - IssueReady = Ready & (IssueAddr == 0 | ~busy[IssueAddr]).
  - Accepted (IssueValid & IssueReady, IssueAddr != 0): busy[IssueAddr] <= 1 on the edge.
  - Issue to an already-busy register stalls (IssueReady=0) until its writeback; this blocks WAW hazards.
- Simultaneous issue accept and write to the same address in one cycle: set wins, so busy ends at 1 and mem takes WriteData.
- Write to a register that is not busy is legal (untracked write); busy stays 0.
- Latency:
  - Write is visible on a stored read the cycle after the edge.
  - With BYPASS, a write is visible on the same cycle.
  - Busy set is visible the cycle after issue.

Test Plan:
- Hold reset=0 for 3 cycles, then release -> Ready=0 for exactly 31 cycles (ADDR_W=5), then 1; every register reads 0; IssueReady=0 throughout CLEAR.
- RUN: write 0xDEADBEEF to r7, read ReadAddr1=7 in the same cycle -> ReadData1=0xDEADBEEF with BYPASS=1, old value 0 with BYPASS=0; next cycle 0xDEADBEEF for both.
- Write 0x12345678 to r0 -> ReadData1 with ReadAddr1=0 stays 0; issue to r0 -> IssueReady=1, Busy1 stays 0.
- Issue r5 -> next cycle Busy2=1 with ReadAddr2=5; a second issue of r5 gives IssueReady=0. Write 0xA5 to r5 -> Busy2=0 in the same cycle (BYPASS=1) and ReadData2=0xA5; IssueReady=1 the next cycle.
- Same cycle: issue r9 accepted and RegWrite r9 = 0x55 -> busy[r9]=1 afterwards and mem[r9]=0x55.
- Mark r3 busy and write r4=0x77, then pull reset low mid-run -> Busy flags 0, Ready=0, a fresh 31-cycle clear runs, and afterwards r4 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file for the pipelined core.
//
// Two combinational read ports, one synchronous write port, an optional
// write-to-read bypass, a per-register busy scoreboard with an issue
// handshake, and a post-reset clear engine that zeroes the storage one entry
// per cycle. Because the storage is never reset directly, it can map to RAM.
//
// Ports
//   clock        single clock, all state updates on the rising edge
//   reset        synchronous active-low reset (0 = reset)
//   Ready        high once the clear sequence has finished (state RUN)
//   RegWrite     writeback write enable
//   WriteAddr    writeback register address
//   WriteData    writeback data
//   ReadAddr1/2  read port addresses
//   ReadData1/2  read port data (combinational)
//   Busy1/2      register at ReadAddr1/2 has a pending write
//   IssueValid   decode requests to mark IssueAddr pending
//   IssueAddr    destination register of the issuing instruction
//   IssueReady   issue is accepted this cycle if IssueValid is high
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              Ready,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic              IssueReady
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [DEPTH-1:0]  busy;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              wr_en;
  logic              issue_fire;
  logic              hit1;
  logic              hit2;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  assign run   = (state == ST_RUN);
  assign Ready = run;

  // A writeback that actually lands in storage: RUN only, never address 0.
  assign wr_en = run && RegWrite && (WriteAddr != '0);

  assign IssueReady = run && ((IssueAddr == '0) || !busy[IssueAddr]);
  assign issue_fire = IssueValid && IssueReady && (IssueAddr != '0);

  // --------------------------------------------------------------------------
  // Control FSM: CLEAR walks ptr from 1 to DEPTH-1, then RUN until reset.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is
    // inferred on paths that do not assign it.
    state_next = state;
    if (state == ST_CLEAR && ptr == '1) state_next = ST_RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_CLEAR;
      ptr   <= ADDR_W'(1);
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) ptr <= ptr + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Single storage write port, shared by the clear engine and writeback.
  // Entry 0 is never written; it reads as constant zero.
  // --------------------------------------------------------------------------
  always_comb begin
    mem_we = 1'b0;
    mem_wa = ptr;
    mem_wd = '0;
    if (reset) begin
      if (!run) begin
        mem_we = 1'b1;
      end else if (wr_en) begin
        mem_we = 1'b1;
        mem_wa = WriteAddr;
        mem_wd = WriteData;
      end
    end
  end

  // NOTE: the storage array has no reset on purpose; the clear engine zeroes
  // it after reset, which keeps it mappable to a RAM macro.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // --------------------------------------------------------------------------
  // Busy scoreboard. Writeback clears first, issue sets last, so an issue and
  // a write to the same register in one cycle leave it busy.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy <= '0;
    end else if (run) begin
      if (wr_en)      busy[WriteAddr] <= 1'b0;
      if (issue_fire) busy[IssueAddr] <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. A bypass hit returns the data being written this cycle and
  // also hides the busy flag, since the value is already available.
  // --------------------------------------------------------------------------
  assign hit1 = (BYPASS != 0) && wr_en && (ReadAddr1 == WriteAddr);
  assign hit2 = (BYPASS != 0) && wr_en && (ReadAddr2 == WriteAddr);

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (run && ReadAddr1 != '0) ReadData1 = hit1 ? WriteData : mem[ReadAddr1];
    if (run && ReadAddr2 != '0) ReadData2 = hit2 ? WriteData : mem[ReadAddr2];
  end

  assign Busy1 = run && (ReadAddr1 != '0) && busy[ReadAddr1] && !hit1;
  assign Busy2 = run && (ReadAddr2 != '0) && busy[ReadAddr2] && !hit2;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed stimulus with hand-computed literal
// expectations, plus a register-file model checked against two instances
// (bypass enabled and disabled) on every negative clock edge.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clock;
  logic              reset;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadAddr1;
  logic [ADDR_W-1:0] ReadAddr2;
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueAddr;

  logic              Ready,      nb_ready;
  logic [DATA_W-1:0] ReadData1,  nb_rd1;
  logic [DATA_W-1:0] ReadData2,  nb_rd2;
  logic              Busy1,      nb_busy1;
  logic              Busy2,      nb_busy2;
  logic              IssueReady, nb_issue_ready;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1)) dut (
    .clock(clock), .reset(reset), .Ready(Ready),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Busy1(Busy1), .Busy2(Busy2),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr), .IssueReady(IssueReady)
  );

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .Ready(nb_ready),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(nb_rd1), .ReadData2(nb_rd2),
    .Busy1(nb_busy1), .Busy2(nb_busy2),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr), .IssueReady(nb_issue_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: register contents, busy set, and how many clear cycles remain.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_busy [DEPTH];
  bit                m_valid = 1'b0;
  bit                m_run   = 1'b0;
  int                m_clear_left = 0;

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a, input bit byp);
    if (!m_run || a == 0) return '0;
    if (byp && RegWrite && WriteAddr != 0 && a == WriteAddr) return WriteData;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a, input bit byp);
    if (!m_run || a == 0) return 1'b0;
    if (byp && RegWrite && WriteAddr != 0 && a == WriteAddr) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_issue_ready();
    return m_run && (IssueAddr == 0 || !m_busy[IssueAddr]);
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_valid      = 1'b1;
      m_run        = 1'b0;
      m_clear_left = DEPTH - 1;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else if (m_valid) begin
      if (!m_run) begin
        m_clear_left--;
        if (m_clear_left == 0) begin
          m_run = 1'b1;
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
      end else begin
        bit ir;
        ir = (IssueAddr == 0) || !m_busy[IssueAddr];
        if (RegWrite && WriteAddr != 0) begin
          m_mem[WriteAddr]  = WriteData;
          m_busy[WriteAddr] = 1'b0;
        end
        if (IssueValid && ir && IssueAddr != 0) m_busy[IssueAddr] = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("ready",          Ready,          m_run);
      check("rd1",            ReadData1,      exp_read(ReadAddr1, 1'b1));
      check("rd2",            ReadData2,      exp_read(ReadAddr2, 1'b1));
      check("busy1",          Busy1,          exp_busy(ReadAddr1, 1'b1));
      check("busy2",          Busy2,          exp_busy(ReadAddr2, 1'b1));
      check("issue_ready",    IssueReady,     exp_issue_ready());
      check("nb_ready",       nb_ready,       m_run);
      check("nb_rd1",         nb_rd1,         exp_read(ReadAddr1, 1'b0));
      check("nb_rd2",         nb_rd2,         exp_read(ReadAddr2, 1'b0));
      check("nb_busy1",       nb_busy1,       exp_busy(ReadAddr1, 1'b0));
      check("nb_busy2",       nb_busy2,       exp_busy(ReadAddr2, 1'b0));
      check("nb_issue_ready", nb_issue_ready, exp_issue_ready());
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus. Inputs change 1 time unit after a rising edge; literal
  // checks happen 1 unit later, well before the falling edge.
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite   = 1'b0;
    WriteAddr  = '0;
    WriteData  = '0;
    IssueValid = 1'b0;
    IssueAddr  = '0;
  endtask

  // Counts cycles with Ready low, starting in the cycle reset is released.
  task automatic count_clear(output int cnt);
    cnt = 0;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (Ready) break;
      if (IssueReady !== 1'b0) check("issue_ready_in_clear", IssueReady, 1'b0);
      cnt++;
      tick();
      #1;
    end
  endtask

  initial begin
    int cnt;
    reset     = 1'b0;
    ReadAddr1 = '0;
    ReadAddr2 = '0;
    idle_inputs();

    // Reset for 3 cycles, then release with write/issue attempts during CLEAR.
    repeat (3) tick();
    #1;
    check("reset_ready", Ready, 1'b0);
    check("reset_rd1",   ReadData1, 32'h0);
    reset      = 1'b1;
    RegWrite   = 1'b1;
    WriteAddr  = 5'd4;
    WriteData  = 32'hFFFF_0000;
    IssueValid = 1'b1;
    IssueAddr  = 5'd3;
    count_clear(cnt);
    check("clear_cycles", cnt, 31);
    idle_inputs();

    // Every register reads 0 after clear.
    for (int a = 0; a < DEPTH; a++) begin
      ReadAddr1 = ADDR_W'(a);
      ReadAddr2 = ADDR_W'(DEPTH - 1 - a);
      #1;
      check("post_clear_rd1", ReadData1, 32'h0);
      check("post_clear_rd2", ReadData2, 32'h0);
    end
    IssueAddr = 5'd3;
    #1;
    check("issue_r3_ready", IssueReady, 1'b1);

    // Write r7 with a same-cycle read.
    tick();
    RegWrite = 1'b1; WriteAddr = 5'd7; WriteData = 32'hDEAD_BEEF; ReadAddr1 = 5'd7;
    #1;
    check("r7_bypass",      ReadData1, 32'hDEAD_BEEF);
    check("r7_no_bypass",   nb_rd1,    32'h0);
    tick();
    idle_inputs();
    #1;
    check("r7_stored",      ReadData1, 32'hDEAD_BEEF);
    check("r7_stored_nb",   nb_rd1,    32'hDEAD_BEEF);

    // Register 0: writes ignored, issue accepted, never busy.
    tick();
    RegWrite = 1'b1; WriteAddr = 5'd0; WriteData = 32'h1234_5678; ReadAddr1 = 5'd0;
    IssueValid = 1'b1; IssueAddr = 5'd0;
    #1;
    check("r0_read",        ReadData1,  32'h0);
    check("r0_issue_ready", IssueReady, 1'b1);
    check("r0_busy",        Busy1,      1'b0);
    tick();
    idle_inputs();
    #1;
    check("r0_read_after",  ReadData1,  32'h0);
    check("r0_busy_after",  Busy1,      1'b0);

    // Issue r5, repeat issue stalls, writeback clears busy.
    tick();
    IssueValid = 1'b1; IssueAddr = 5'd5; ReadAddr2 = 5'd5;
    #1;
    check("r5_issue_ready", IssueReady, 1'b1);
    check("r5_busy_before", Busy2,      1'b0);
    tick();
    #1;
    check("r5_busy",        Busy2,      1'b1);
    check("r5_reissue",     IssueReady, 1'b0);
    tick();
    IssueValid = 1'b0; RegWrite = 1'b1; WriteAddr = 5'd5; WriteData = 32'h0000_00A5;
    #1;
    check("r5_wb_busy",     Busy2,      1'b0);
    check("r5_wb_rd2",      ReadData2,  32'h0000_00A5);
    check("r5_wb_busy_nb",  nb_busy2,   1'b1);
    check("r5_wb_rd2_nb",   nb_rd2,     32'h0);
    tick();
    idle_inputs();
    IssueValid = 1'b1; IssueAddr = 5'd5;
    #1;
    check("r5_issue_again", IssueReady, 1'b1);
    check("r5_busy_clear",  Busy2,      1'b0);

    // Same-cycle issue and write to r9: set wins.
    tick();
    IssueValid = 1'b1; IssueAddr = 5'd9;
    RegWrite = 1'b1; WriteAddr = 5'd9; WriteData = 32'h0000_0055; ReadAddr1 = 5'd9;
    #1;
    check("r9_issue_ready", IssueReady, 1'b1);
    check("r9_bypass",      ReadData1,  32'h0000_0055);
    tick();
    idle_inputs();
    #1;
    check("r9_busy",        Busy1,      1'b1);
    check("r9_stored",      ReadData1,  32'h0000_0055);

    // Busy r3, write r4, then reset mid-run.
    tick();
    IssueValid = 1'b1; IssueAddr = 5'd3;
    tick();
    idle_inputs();
    RegWrite = 1'b1; WriteAddr = 5'd4; WriteData = 32'h0000_0077;
    ReadAddr1 = 5'd3; ReadAddr2 = 5'd4;
    #1;
    check("r3_busy",        Busy1,      1'b1);
    check("r4_bypass",      ReadData2,  32'h0000_0077);
    tick();
    idle_inputs();
    #1;
    check("r4_stored",      ReadData2,  32'h0000_0077);
    reset = 1'b0;
    tick();
    #1;
    check("rst2_ready",     Ready,      1'b0);
    check("rst2_busy1",     Busy1,      1'b0);
    check("rst2_rd2",       ReadData2,  32'h0);
    reset = 1'b1;
    count_clear(cnt);
    check("clear_cycles_2", cnt, 31);
    IssueAddr = 5'd3;
    #1;
    check("rst2_r4_zero",   ReadData2,  32'h0);
    check("rst2_r3_free",   Busy1,      1'b0);
    check("rst2_issue_r3",  IssueReady, 1'b1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
